adaptive_filter_sched: RTL and testbench
========================================

ADAPTIVE_FILTER_SCHED -- requirements
Module: adaptive_filter_sched

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles f_srst is held high per mode switch (legal 1..15).
REQ-002 Parameter WARMUP_SAMPLES, default FIR_DIFF_ORDER, number of post-switch output samples blanked.
REQ-003 Parameter RESET_MODE, default 1'b0, filter mode after reset (1 = integrator, 0 = differentiator).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 mode_req  in  1  requested filter mode.
REQ-007 mode_req_valid  in  1  mode request present.
REQ-008 mode_req_ready  out  1  request accepted this cycle.
REQ-009 s_tdata  in  14 (Q8.6, [7:-6])  upstream sample.
REQ-010 s_tvalid  in  1  upstream sample valid.
REQ-011 s_tready  out  1  sample accepted this cycle.
REQ-012 f_ctrl  out  1  filter mode select.
REQ-013 f_srst  out  1  synchronous active-high filter clear.
REQ-014 f_tdata  out  14  sample to filter.
REQ-015 f_tvalid  out  1  sample valid to filter.
REQ-016 f_m_tdata  in  14  filter result.
REQ-017 f_m_tvalid  in  1  filter result valid (filter latency = 1 cycle).
REQ-018 m_tdata  out  14  result downstream.
REQ-019 m_tvalid  out  1  result valid downstream.
REQ-020 busy  out  1  high in any state other than RUN.

Function
REQ-021 FSM states RUN, DRAIN, FLUSH, encoded as enum mode_sched_state_t.
REQ-022 s_tready = mode_req_ready = (state == RUN); f_tdata = s_tdata; f_tvalid = s_tvalid & s_tready (combinational).
REQ-023 RUN: mode_req_valid with mode_req == f_ctrl -> accepted, no state change, no f_srst.
REQ-024 RUN: mode_req_valid with mode_req != f_ctrl -> accepted, pending mode latched, next state DRAIN.
REQ-025 Simultaneous s_tvalid and switching request in RUN: the sample is forwarded under the old mode before DRAIN.
REQ-026 DRAIN lasts exactly 1 cycle (captures last f_m_tvalid), then FLUSH.
REQ-027 FLUSH: f_srst = 1 for exactly FLUSH_CYCLES cycles via 4-bit down-counter; f_ctrl takes pending mode on FLUSH entry; then RUN.
REQ-028 Switch cost: RUN stalled 1 + FLUSH_CYCLES cycles; f_ctrl never changes while f_srst = 0.
REQ-029 m_tdata = f_m_tdata; m_tvalid = f_m_tvalid & ~blank (combinational).
REQ-030 Warm-up counter loads WARMUP_SAMPLES on FLUSH exit, decrements per f_m_tvalid, saturates at 0; blank = (counter != 0).
REQ-031 WARMUP_SAMPLES = 0 -> no blanking.
REQ-032 mode_req_valid in DRAIN/FLUSH is not accepted; requester holds it until ready.

Reset
REQ-033 arst_n low: state = FLUSH, counter = FLUSH_CYCLES, f_ctrl = RESET_MODE, warm-up = WARMUP_SAMPLES, f_srst = 1, s_tready = 0, mode_req_ready = 0, busy = 1.
REQ-034 Reset asserted mid-switch aborts the switch; pending mode discarded; f_ctrl returns to RESET_MODE.

Configuration
REQ-035 Macro ADAPTIVE_FILTER_SCHED_WARMUP_EN defined: REQ-030/031 blanking active.
REQ-036 Macro undefined: warm-up counter absent, m_tvalid = f_m_tvalid, WARMUP_SAMPLES ignored.

Structure
REQ-037 mode_sched_state_t and FLUSH_CYCLES_MAX (15) added to adaptive_filter_pkg; FIR_DIFF_ORDER reused from it.
REQ-038 Single flat module, no sub-modules; a testbench top instantiates it with adaptive_filter.

Verification
REQ-039 Reset release, FLUSH_CYCLES=2 -> f_srst high 2 cycles after arst_n rises, then s_tready = 1, f_ctrl = 0.
REQ-040 In RUN, mode_req=1 pulse -> DRAIN 1 cycle, f_srst 2 cycles with f_ctrl = 1, s_tready = 0 for 3 cycles total.
REQ-041 mode_req = current mode -> mode_req_ready same cycle, busy stays 0, no f_srst.
REQ-042 s_tvalid with data 0x0040 and switching request same cycle -> f_tvalid = 1 with old f_ctrl; m_tvalid 1 cycle later.
REQ-043 WARMUP_EN, WARMUP_SAMPLES=4, continuous input after switch -> first 4 f_m_tvalid blanked, 5th passed.
REQ-044 arst_n pulsed low during FLUSH -> f_ctrl = RESET_MODE, FLUSH restarts with full count.

Source files
------------

// File: rtl/adaptive_filter_pkg.sv
// -----------------------------------------------------------------------------
// adaptive_filter_pkg
// Purpose : shared types and constants for the adaptive filter datapath and its
//           mode-switch scheduler.
// Contents: sample width, FIR differentiator order, flush-counter limits,
//           warm-up counter width, scheduler FSM state type.
// -----------------------------------------------------------------------------
package adaptive_filter_pkg;

  // Q8.6 sample, bits [7:-6]
  localparam int unsigned SAMPLE_W         = 14;

  // Differentiator tap order; also the default number of settling samples
  localparam int unsigned FIR_DIFF_ORDER   = 4;

  // Flush length limit and the down-counter that times it
  localparam int unsigned FLUSH_CYCLES_MAX = 15;
  localparam int unsigned FLUSH_CNT_W      = 4;

  // Warm-up blanking counter width (WARMUP_SAMPLES must fit)
  localparam int unsigned WARM_CNT_W       = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } mode_sched_state_t;

endpackage : adaptive_filter_pkg

// File: rtl/adaptive_filter_sched.sv
// -----------------------------------------------------------------------------
// adaptive_filter_sched
// Purpose : schedules integrator/differentiator mode switches of the adaptive
//           filter. A switch stalls the upstream stream, lets the last result
//           drain, holds the filter in synchronous clear for FLUSH_CYCLES while
//           the new mode is applied, and optionally blanks the first
//           WARMUP_SAMPLES results after the switch.
// Config  : `define ADAPTIVE_FILTER_SCHED_WARMUP_EN enables warm-up blanking;
//           without it m_tvalid = f_m_tvalid and WARMUP_SAMPLES is ignored.
// Ports   :
//   clk, arst_n                    clock, async active-low reset
//   mode_req/_valid/_ready         mode-change request handshake
//   s_tdata/s_tvalid/s_tready      upstream sample stream (Q8.6)
//   f_ctrl, f_srst                 filter mode select, filter sync clear
//   f_tdata/f_tvalid               sample to filter
//   f_m_tdata/f_m_tvalid           filter result (1-cycle latency)
//   m_tdata/m_tvalid               result downstream
//   busy                           high whenever not in RUN
// -----------------------------------------------------------------------------
module adaptive_filter_sched
  import adaptive_filter_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned WARMUP_SAMPLES = FIR_DIFF_ORDER,
  parameter logic        RESET_MODE     = 1'b0
) (
  input  logic                clk,
  input  logic                arst_n,

  input  logic                mode_req,
  input  logic                mode_req_valid,
  output logic                mode_req_ready,

  input  logic [SAMPLE_W-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,

  output logic                f_ctrl,
  output logic                f_srst,
  output logic [SAMPLE_W-1:0] f_tdata,
  output logic                f_tvalid,

  input  logic [SAMPLE_W-1:0] f_m_tdata,
  input  logic                f_m_tvalid,

  output logic [SAMPLE_W-1:0] m_tdata,
  output logic                m_tvalid,

  output logic                busy
);

  // Elaboration-time parameter range check
  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ||
      (WARMUP_SAMPLES >= (2 ** WARM_CNT_W))) begin : g_bad_param
    $error("adaptive_filter_sched: parameter out of range");
  end

  mode_sched_state_t        r_state;
  mode_sched_state_t        w_state_nxt;
  logic [FLUSH_CNT_W-1:0]   r_flush_cnt;
  logic [FLUSH_CNT_W-1:0]   w_flush_cnt_nxt;
  logic                     r_f_ctrl;
  logic                     w_f_ctrl_nxt;
  logic                     r_pending;
  logic                     w_pending_nxt;
  logic                     w_flush_done;

  // State and control registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= FLUSH;
      r_flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
      r_f_ctrl    <= RESET_MODE;
      r_pending   <= RESET_MODE;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_f_ctrl    <= w_f_ctrl_nxt;
      r_pending   <= w_pending_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_f_ctrl_nxt    = r_f_ctrl;
    w_pending_nxt   = r_pending;
    w_flush_done    = 1'b0;
    s_tready        = 1'b0;
    mode_req_ready  = 1'b0;
    f_srst          = 1'b0;
    busy            = 1'b1;

    case (r_state)
      RUN: begin
        s_tready       = 1'b1;
        mode_req_ready = 1'b1;
        busy           = 1'b0;
        // Same-mode requests are simply acknowledged
        if (mode_req_valid && (mode_req != r_f_ctrl)) begin
          w_pending_nxt = mode_req;
          w_state_nxt   = DRAIN;
        end
      end

      DRAIN: begin
        // Mode changes only together with f_srst rising
        w_state_nxt     = FLUSH;
        w_flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES);
        w_f_ctrl_nxt    = r_pending;
      end

      FLUSH: begin
        f_srst = 1'b1;
        if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
          w_flush_done = 1'b1;
          w_state_nxt  = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
        end
      end

      default: begin
        f_srst      = 1'b1;
        w_state_nxt = FLUSH;
      end
    endcase
  end

  assign f_ctrl   = r_f_ctrl;
  assign f_tdata  = s_tdata;
  assign f_tvalid = s_tvalid & s_tready;
  assign m_tdata  = f_m_tdata;

`ifdef ADAPTIVE_FILTER_SCHED_WARMUP_EN
  logic [WARM_CNT_W-1:0] r_warm;
  logic [WARM_CNT_W-1:0] w_warm_nxt;

  // Warm-up counter: reload on flush exit, count results down to zero
  always_comb begin
    w_warm_nxt = r_warm;
    if (w_flush_done) begin
      w_warm_nxt = WARM_CNT_W'(WARMUP_SAMPLES);
    end else if (f_m_tvalid && (r_warm != '0)) begin
      w_warm_nxt = r_warm - WARM_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_warm <= WARM_CNT_W'(WARMUP_SAMPLES);
    end else begin
      r_warm <= w_warm_nxt;
    end
  end

  assign m_tvalid = f_m_tvalid & (r_warm == '0);
`else
  assign m_tvalid = f_m_tvalid;
`endif

endmodule : adaptive_filter_sched

// File: tb/tb_adaptive_filter_sched.sv
// -----------------------------------------------------------------------------
// tb_adaptive_filter_sched
// Purpose : directed self-checking bench for adaptive_filter_sched with a
//           1-cycle-latency pass-through filter stand-in. Honours
//           ADAPTIVE_FILTER_SCHED_WARMUP_EN for the blanking expectations.
// -----------------------------------------------------------------------------
module tb_adaptive_filter_sched;

  localparam int unsigned SW = 14;
  localparam int unsigned WS = 4;
`ifdef ADAPTIVE_FILTER_SCHED_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst_n;
  logic          mode_req;
  logic          mode_req_valid;
  logic          mode_req_ready;
  logic [SW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          f_ctrl;
  logic          f_srst;
  logic [SW-1:0] f_tdata;
  logic          f_tvalid;
  logic [SW-1:0] f_m_tdata;
  logic          f_m_tvalid;
  logic [SW-1:0] m_tdata;
  logic          m_tvalid;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adaptive_filter_sched #(
    .FLUSH_CYCLES   (2),
    .WARMUP_SAMPLES (WS),
    .RESET_MODE     (1'b0)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .f_ctrl         (f_ctrl),
    .f_srst         (f_srst),
    .f_tdata        (f_tdata),
    .f_tvalid       (f_tvalid),
    .f_m_tdata      (f_m_tdata),
    .f_m_tvalid     (f_m_tvalid),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .busy           (busy)
  );

  // Filter stand-in: 1-cycle latency, cleared by f_srst
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      f_m_tvalid <= 1'b0;
      f_m_tdata  <= '0;
    end else if (f_srst) begin
      f_m_tvalid <= 1'b0;
      f_m_tdata  <= '0;
    end else begin
      f_m_tvalid <= f_tvalid;
      f_m_tdata  <= f_tdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous input stream of WS+1 samples; first WS blanked when warm-up on
  task automatic stream(input logic [SW-1:0] base, input string tag);
    logic [SW-1:0] d;
    for (int k = 0; k <= int'(WS); k++) begin
      d        = base + SW'(k);
      s_tdata  = d;
      s_tvalid = 1'b1;
      tick();
      chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'((WARM && k < int'(WS)) ? 1'b0 : 1'b1));
      chk({tag, "_m_tdata"},  32'(m_tdata),  32'(d));
    end
    s_tvalid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n         = 1'b0;
    mode_req       = 1'b0;
    mode_req_valid = 1'b0;
    s_tdata        = '0;
    s_tvalid       = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_srst",    32'(f_srst),         32'd1);
    chk("rst_s_tready",32'(s_tready),       32'd0);
    chk("rst_mrr",     32'(mode_req_ready), 32'd0);
    chk("rst_busy",    32'(busy),           32'd1);
    chk("rst_f_ctrl",  32'(f_ctrl),         32'd0);

    // Reset release: two flush cycles then RUN
    arst_n = 1'b1;
    tick();
    chk("rel_srst1",   32'(f_srst),   32'd1);
    chk("rel_busy1",   32'(busy),     32'd1);
    tick();
    chk("rel_srst_run",32'(f_srst),   32'd0);
    chk("rel_s_tready",32'(s_tready), 32'd1);
    chk("rel_f_ctrl",  32'(f_ctrl),   32'd0);
    chk("rel_busy",    32'(busy),     32'd0);

    // Same-mode request: accepted, no switch
    mode_req = 1'b0; mode_req_valid = 1'b1;
    #1;
    chk("same_mrr",    32'(mode_req_ready), 32'd1);
    tick();
    mode_req_valid = 1'b0;
    chk("same_busy",   32'(busy),   32'd0);
    chk("same_srst",   32'(f_srst), 32'd0);

    // Warm-up after the reset flush
    stream(14'h0010, "post_rst");

    // Sample and switching request in the same RUN cycle
    s_tdata = 14'h0040; s_tvalid = 1'b1;
    mode_req = 1'b1; mode_req_valid = 1'b1;
    #1;
    chk("sim_f_tvalid",32'(f_tvalid),       32'd1);
    chk("sim_f_ctrl",  32'(f_ctrl),         32'd0);
    chk("sim_f_tdata", 32'(f_tdata),        32'h40);
    chk("sim_mrr",     32'(mode_req_ready), 32'd1);
    tick();
    s_tvalid = 1'b0;
    chk("drain_busy",  32'(busy),     32'd1);
    chk("drain_stall", 32'(s_tready), 32'd0);
    chk("drain_srst",  32'(f_srst),   32'd0);
    chk("drain_f_ctrl",32'(f_ctrl),   32'd0);
    chk("drain_m_tv",  32'(m_tvalid), 32'd1);
    chk("drain_m_td",  32'(m_tdata),  32'h40);

    // New request during the switch is held off until RUN
    mode_req = 1'b0; mode_req_valid = 1'b1;
    #1;
    chk("drain_mrr",   32'(mode_req_ready), 32'd0);
    tick();
    chk("fl1_srst",    32'(f_srst),         32'd1);
    chk("fl1_f_ctrl",  32'(f_ctrl),         32'd1);
    chk("fl1_stall",   32'(s_tready),       32'd0);
    chk("fl1_mrr",     32'(mode_req_ready), 32'd0);
    tick();
    chk("fl2_srst",    32'(f_srst),   32'd1);
    chk("fl2_stall",   32'(s_tready), 32'd0);
    tick();
    chk("sw1_srst",    32'(f_srst),         32'd0);
    chk("sw1_s_tready",32'(s_tready),       32'd1);
    chk("sw1_f_ctrl",  32'(f_ctrl),         32'd1);
    chk("sw1_mrr",     32'(mode_req_ready), 32'd1);

    // Held request now switches back to mode 0
    tick();
    mode_req_valid = 1'b0;
    chk("sw0_drain_busy",  32'(busy),   32'd1);
    chk("sw0_drain_f_ctrl",32'(f_ctrl), 32'd1);
    tick();
    chk("sw0_fl_f_ctrl",   32'(f_ctrl), 32'd0);
    chk("sw0_fl_srst",     32'(f_srst), 32'd1);
    tick();
    tick();
    chk("sw0_run_busy",    32'(busy),   32'd0);
    chk("sw0_run_f_ctrl",  32'(f_ctrl), 32'd0);

    // Warm-up after a mode switch
    stream(14'h0100, "post_sw");

    // Reset in the middle of FLUSH aborts the switch
    mode_req = 1'b1; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    tick();
    chk("ab_fl_f_ctrl", 32'(f_ctrl), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("ab_rst_f_ctrl",32'(f_ctrl), 32'd0);
    chk("ab_rst_srst",  32'(f_srst), 32'd1);
    chk("ab_rst_busy",  32'(busy),   32'd1);
    #2 arst_n = 1'b1;
    tick();
    chk("ab_fl1_srst",  32'(f_srst), 32'd1);
    chk("ab_fl1_f_ctrl",32'(f_ctrl), 32'd0);
    tick();
    chk("ab_run_srst",  32'(f_srst),   32'd0);
    chk("ab_run_rdy",   32'(s_tready), 32'd1);
    chk("ab_run_f_ctrl",32'(f_ctrl),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_adaptive_filter_sched
